dest_header_insert: RTL and testbench

- Parametrised successor of the single-beat destination inserter on the AXI4-Stream packetizer path.
- Prepends a configurable multi-beat header carrying the packet's TID in front of each outgoing packet, ahead of the serial/byte transport.
- Supports generic data/ID widths, a multi-beat header, and an optional "insert only on TID change" mode.
- Output is fully registered: one output stage, full throughput, no combinational valid/data path from target to initiator.

---
 rtl/dest_header_insert.sv | 177 +++++++++++++++++
 tb/tb_dest_header_insert.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_header_insert.sv
// dest_header_insert
//   Prepends a HDR_BEATS-beat header carrying the packet TID to each packet
//   on an AXI4-Stream path. The header word is the TID zero-extended to
//   HDR_BEATS*DATA_WIDTH bits and is sent least-significant slice first.
//   With INSERT_MODE=1 a header is only sent when the TID differs from the
//   TID of the last header sent. The output is a single registered stage
//   that sustains one beat per cycle.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   target_tvalid/tready     input stream handshake (tready is combinational)
//   target_tlast/tdata/tid   input end-of-packet, payload, destination id
//   initiator_tvalid/tready  output stream handshake (tvalid registered)
//   initiator_tlast/tdata    output end-of-packet and header/payload (registered)
module dest_header_insert #(
  parameter int DATA_WIDTH  = 8,
  parameter int ID_WIDTH    = 3,
  parameter int HDR_BEATS   = 1,
  parameter int INSERT_MODE = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  target_tvalid,
  output logic                  target_tready,
  input  logic                  target_tlast,
  input  logic [DATA_WIDTH-1:0] target_tdata,
  input  logic [ID_WIDTH-1:0]   target_tid,
  output logic                  initiator_tvalid,
  input  logic                  initiator_tready,
  output logic                  initiator_tlast,
  output logic [DATA_WIDTH-1:0] initiator_tdata
);

  localparam int HDR_W = HDR_BEATS * DATA_WIDTH;
  localparam int CNT_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("dest_header_insert: DATA_WIDTH must be at least 1");
  end
  if (HDR_BEATS < 1 || HDR_BEATS > 16) begin : g_bad_hdr_beats
    $error("dest_header_insert: HDR_BEATS must be in 1..16");
  end
  if (ID_WIDTH > HDR_W) begin : g_bad_id_width
    $error("dest_header_insert: ID_WIDTH must not exceed HDR_BEATS*DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [ID_WIDTH-1:0]   hdr_tid_q, hdr_tid_d;
  logic [ID_WIDTH-1:0]   last_tid_q, last_tid_d;
  logic                  last_tid_valid_q, last_tid_valid_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

  logic                  slot_free;
  logic                  insert_needed;
  logic [HDR_W-1:0]      hdr_word_new;   // header built from the live input tid (beat 0)
  logic [HDR_W-1:0]      hdr_word_q;     // header built from the captured tid (beats 1..)
  logic [DATA_WIDTH-1:0] hdr_beat [HDR_BEATS];
  logic [DATA_WIDTH-1:0] hdr_cur;

  assign slot_free     = !tvalid_q || initiator_tready;
  assign insert_needed = (INSERT_MODE == 0) || !last_tid_valid_q || (target_tid != last_tid_q);

  assign hdr_word_new = HDR_W'(target_tid);
  assign hdr_word_q   = HDR_W'(hdr_tid_q);

  for (genvar gi = 0; gi < HDR_BEATS; gi++) begin : g_hdr_slice
    assign hdr_beat[gi] = hdr_word_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Explicit compare mux keeps the beat select in range for any HDR_BEATS.
  always_comb begin
    hdr_cur = '0;
    for (int k = 0; k < HDR_BEATS; k++) begin
      if (hdr_cnt_q == CNT_W'(k)) hdr_cur = hdr_beat[k];
    end
  end

  always_comb begin
    state_d          = state_q;
    hdr_cnt_d        = hdr_cnt_q;
    hdr_tid_d        = hdr_tid_q;
    last_tid_d       = last_tid_q;
    last_tid_valid_d = last_tid_valid_q;
    // A consumed beat with nothing new behind it leaves the register empty.
    tvalid_d         = tvalid_q && !slot_free;
    tlast_d          = tlast_q;
    tdata_d          = tdata_q;
    target_tready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The first beat is held off while a header is due, so the header
        // can be launched from its tid without storing the payload beat.
        target_tready = slot_free && !insert_needed;
        if (target_tvalid && slot_free) begin
          if (insert_needed) begin
            hdr_tid_d        = target_tid;
            last_tid_d       = target_tid;
            last_tid_valid_d = 1'b1;
            tvalid_d         = 1'b1;
            tlast_d          = 1'b0;
            tdata_d          = hdr_word_new[DATA_WIDTH-1:0];
            if (HDR_BEATS > 1) begin
              hdr_cnt_d = CNT_W'(1);
              state_d   = HEADER;
            end else begin
              state_d   = PAYLOAD;
            end
          end else begin
            tvalid_d = 1'b1;
            tlast_d  = target_tlast;
            tdata_d  = target_tdata;
            state_d  = target_tlast ? IDLE : PAYLOAD;
          end
        end
      end

      HEADER: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = hdr_cur;
          if (hdr_cnt_q == CNT_W'(HDR_BEATS - 1)) begin
            hdr_cnt_d = '0;
            state_d   = PAYLOAD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
          end
        end
      end

      PAYLOAD: begin
        target_tready = slot_free;
        if (target_tvalid && slot_free) begin
          tvalid_d = 1'b1;
          tlast_d  = target_tlast;
          tdata_d  = target_tdata;
          if (target_tlast) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= IDLE;
      hdr_cnt_q        <= '0;
      hdr_tid_q        <= '0;
      last_tid_q       <= '0;
      last_tid_valid_q <= 1'b0;
      tvalid_q         <= 1'b0;
      tlast_q          <= 1'b0;
      tdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      hdr_cnt_q        <= hdr_cnt_d;
      hdr_tid_q        <= hdr_tid_d;
      last_tid_q       <= last_tid_d;
      last_tid_valid_q <= last_tid_valid_d;
      tvalid_q         <= tvalid_d;
      tlast_q          <= tlast_d;
      tdata_q          <= tdata_d;
    end
  end

  assign initiator_tvalid = tvalid_q;
  assign initiator_tlast  = tlast_q;
  assign initiator_tdata  = tdata_q;

endmodule

// File: tb/tb_dest_header_insert.sv
// Testbench for dest_header_insert. Two instances run side by side:
//   dut_a : DATA_WIDTH=8, ID_WIDTH=3,  HDR_BEATS=1, INSERT_MODE=0
//   dut_b : DATA_WIDTH=8, ID_WIDTH=12, HDR_BEATS=4, INSERT_MODE=1
// Each packet handed to a driver is also expanded by a packet-level model
// into the expected output beat list; a single compare process checks every
// transferred output beat against that list and checks output stability
// under backpressure.
module tb_dest_header_insert;

  logic       aclk = 1'b0;
  logic       aresetn;
  always #5 aclk = ~aclk;

  logic [1:0]  t_valid, t_last, i_ready;
  logic [7:0]  t_data [2];
  logic [11:0] t_tid  [2];
  logic        a_t_ready, b_t_ready, a_o_valid, b_o_valid, a_o_last, b_o_last;
  logic [7:0]  a_o_data, b_o_data;

  logic [1:0]  t_ready, o_valid, o_last;
  logic [7:0]  o_data [2];
  assign t_ready   = {b_t_ready, a_t_ready};
  assign o_valid   = {b_o_valid, a_o_valid};
  assign o_last    = {b_o_last, a_o_last};
  assign o_data[0] = a_o_data;
  assign o_data[1] = b_o_data;

  dest_header_insert #(.DATA_WIDTH(8), .ID_WIDTH(3), .HDR_BEATS(1), .INSERT_MODE(0)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(t_valid[0]), .target_tready(a_t_ready), .target_tlast(t_last[0]),
    .target_tdata(t_data[0]), .target_tid(t_tid[0][2:0]),
    .initiator_tvalid(a_o_valid), .initiator_tready(i_ready[0]),
    .initiator_tlast(a_o_last), .initiator_tdata(a_o_data));

  dest_header_insert #(.DATA_WIDTH(8), .ID_WIDTH(12), .HDR_BEATS(4), .INSERT_MODE(1)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(t_valid[1]), .target_tready(b_t_ready), .target_tlast(t_last[1]),
    .target_tdata(t_data[1]), .target_tid(t_tid[1]),
    .initiator_tvalid(b_o_valid), .initiator_tready(i_ready[1]),
    .initiator_tlast(b_o_last), .initiator_tdata(b_o_data));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- model ----------------
  logic [8:0]  exp_q0[$], exp_q1[$];
  logic [8:0]  obs0[$], obs1[$];
  int          obsc0[$], obsc1[$];
  logic [11:0] m_last_tid [2];
  bit          m_last_vld [2];
  logic [7:0]  pl_buf [2][16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hdr_beats(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic void exp_push(input int i, input logic [8:0] v);
    if (i == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  // Expand one packet into the beats that must appear on the output.
  task automatic model_pkt(input int i, input logic [11:0] tid, input int len);
    logic [127:0] h;
    logic [11:0]  t;
    bit           ins;
    t   = (i == 0) ? (tid & 12'h007) : tid;
    ins = (i == 0) || !m_last_vld[i] || (t != m_last_tid[i]);
    if (ins) begin
      m_last_vld[i] = 1'b1;
      m_last_tid[i] = t;
      h = 128'(t);
      for (int k = 0; k < hdr_beats(i); k++) exp_push(i, {1'b0, 8'(h >> (8*k))});
    end
    for (int k = 0; k < len; k++) exp_push(i, {(k == len-1), pl_buf[i][k]});
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_last_vld[0] = 1'b0;
    m_last_vld[1] = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called and returns at posedge+1. stall0 counts cycles the first beat waited.
  task automatic send_pkt(input int i, input logic [11:0] tid, input int len,
                          input int max_gap, input bit junk_tid,
                          output int stall0, output int start_cyc);
    int n;
    int gap;
    model_pkt(i, tid, len);
    stall0 = 0;
    start_cyc = 0;
    for (int k = 0; k < len; k++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin @(posedge aclk); #1; end
      t_valid[i] = 1'b1;
      t_data[i]  = pl_buf[i][k];
      t_last[i]  = (k == len-1);
      t_tid[i]   = (k > 0 && junk_tid && ($urandom_range(0, 3) == 0)) ? 12'($urandom) : tid;
      if (k == 0) start_cyc = cyc;
      n = 0;
      @(negedge aclk);
      while (!t_ready[i] && n < 300) begin
        n++;
        @(negedge aclk);
      end
      if (n >= 300) chk($sformatf("dut%0d_accept_timeout", i), t_ready[i], 1);
      if (k == 0) stall0 = n;
      @(posedge aclk); #1;
      t_valid[i] = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
      @(posedge aclk); #1;
      n++;
    end
    chk({name, "_a_left"}, exp_q0.size(), 0);
    chk({name, "_b_left"}, exp_q1.size(), 0);
  endtask

  // ---------------- output ready ----------------
  initial begin
    i_ready = 2'b11;
    forever begin
      @(posedge aclk); #1;
      i_ready = rand_rdy ? 2'($urandom) : 2'b11;
    end
  end

  // ---------------- compare process ----------------
  bit         prv_stall [2];
  logic [8:0] prv_beat  [2];
  initial begin
    logic [8:0] cur;
    logic [8:0] e;
    prv_stall[0] = 1'b0;
    prv_stall[1] = 1'b0;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < 2; i++) begin
        if (!aresetn) begin
          prv_stall[i] = 1'b0;
        end else begin
          cur = {o_last[i], o_data[i]};
          if (prv_stall[i]) begin
            chk($sformatf("dut%0d_hold_valid", i), o_valid[i], 1);
            chk($sformatf("dut%0d_hold_beat", i), cur, prv_beat[i]);
          end
          if (o_valid[i] && i_ready[i]) begin
            if (i == 0) begin obs0.push_back(cur); obsc0.push_back(cyc); end
            else        begin obs1.push_back(cur); obsc1.push_back(cyc); end
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
              chk($sformatf("dut%0d_unexpected_beat", i), o_valid[i], 0);
            end else begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("dut%0d_beat", i), cur, e);
            end
          end
          prv_stall[i] = o_valid[i] && !i_ready[i];
          prv_beat[i]  = cur;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] lit_a [7];
  logic [8:0] lit_b [5];
  int exp_stall_b [4];
  logic [11:0] tids_b [4];

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_dut%0d_tvalid", name, i), o_valid[i], 0);
      chk($sformatf("%s_dut%0d_tlast", name, i), o_last[i], 0);
      chk($sformatf("%s_dut%0d_tdata", name, i), o_data[i], 0);
      chk($sformatf("%s_dut%0d_tready", name, i), t_ready[i], 0);
    end
  endtask

  initial begin
    int st, sc, sc_a, n;
    t_valid = '0; t_last = '0;
    t_data[0] = '0; t_data[1] = '0; t_tid[0] = '0; t_tid[1] = '0;
    m_last_vld[0] = 1'b0; m_last_vld[1] = 1'b0;
    m_last_tid[0] = '0;   m_last_tid[1] = '0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    t_valid = 2'b11;   // ready must stay low while reset is held
    #1;
    check_zero("reset");
    t_valid = 2'b00;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // ---- directed: known streams with hand-computed beats ----
    obs0.delete(); obsc0.delete(); obs1.delete(); obsc1.delete();
    fork
      begin
        pl_buf[0][0] = 8'h11; pl_buf[0][1] = 8'h22; pl_buf[0][2] = 8'h33;
        send_pkt(0, 12'd5, 3, 0, 1'b0, st, sc_a);
        chk("a_first_stall", st, 1);
        pl_buf[0][0] = 8'h44; pl_buf[0][1] = 8'h55;
        send_pkt(0, 12'd5, 2, 0, 1'b0, st, sc);
        chk("a_b2b_stall", st, 1);
        n = 0;
        while (obs0.size() < 7 && n < 50) begin @(posedge aclk); #1; n++; end
        chk("a_obs_count", obs0.size(), 7);
        lit_a = '{9'h005, 9'h011, 9'h022, 9'h133, 9'h005, 9'h044, 9'h155};
        for (int k = 0; k < 7 && k < obs0.size(); k++) begin
          chk($sformatf("a_lit_beat%0d", k), obs0[k], lit_a[k]);
          chk($sformatf("a_lit_cycle%0d", k), obsc0[k], sc_a + 1 + k);
        end
      end
      begin
        int st_b, sc_b, nb;
        pl_buf[1][0] = 8'h7E;
        send_pkt(1, 12'hABC, 1, 0, 1'b0, st_b, sc_b);
        chk("b_hdr_stall", st_b, 4);
        nb = 0;
        while (obs1.size() < 5 && nb < 50) begin @(posedge aclk); #1; nb++; end
        chk("b_obs_count", obs1.size(), 5);
        lit_b = '{9'h0BC, 9'h00A, 9'h000, 9'h000, 9'h17E};
        for (int k = 0; k < 5 && k < obs1.size(); k++) begin
          chk($sformatf("b_lit_beat%0d", k), obs1[k], lit_b[k]);
          chk($sformatf("b_lit_cycle%0d", k), obsc1[k], sc_b + 1 + k);
        end
        // repeated tid skips the header and is accepted without a bubble
        tids_b      = '{12'd2, 12'd2, 12'd3, 12'd3};
        exp_stall_b = '{4, 0, 4, 0};
        for (int p = 0; p < 4; p++) begin
          pl_buf[1][0] = 8'($urandom); pl_buf[1][1] = 8'($urandom);
          send_pkt(1, tids_b[p], 2, 0, 1'b0, st_b, sc_b);
          chk($sformatf("b_mode1_stall%0d", p), st_b, exp_stall_b[p]);
        end
      end
    join
    drain("directed");

    // ---- random traffic with backpressure and input gaps ----
    rand_rdy = 1'b1;
    fork
      begin
        int s0, c0, len0;
        for (int p = 0; p < 1000; p++) begin
          len0 = $urandom_range(1, 4);
          for (int k = 0; k < len0; k++) pl_buf[0][k] = 8'($urandom);
          send_pkt(0, 12'($urandom_range(0, 7)), len0, 2, 1'b1, s0, c0);
        end
      end
      begin
        int s1, c1, len1;
        for (int p = 0; p < 1000; p++) begin
          len1 = $urandom_range(1, 4);
          for (int k = 0; k < len1; k++) pl_buf[1][k] = 8'($urandom);
          send_pkt(1, 12'($urandom_range(0, 5)), len1, 2, 1'b1, s1, c1);
        end
      end
    join
    rand_rdy = 1'b0;
    i_ready  = 2'b11;
    drain("random");

    // ---- reset in the middle of dut_b's header ----
    pl_buf[1][0] = 8'h55; pl_buf[1][1] = 8'h66;
    model_pkt(1, 12'h123, 2);
    t_valid[1] = 1'b1; t_tid[1] = 12'h123; t_data[1] = 8'h55; t_last[1] = 1'b0;
    @(posedge aclk); @(posedge aclk); #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check_zero("rst_hdr");
    t_valid[1] = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    pl_buf[1][0] = 8'h55; pl_buf[1][1] = 8'h66;
    send_pkt(1, 12'h123, 2, 0, 1'b0, st, sc);
    chk("rst_hdr_repeat_tid_stall", st, 4);
    drain("rst_hdr");

    // ---- reset in the middle of dut_a's payload ----
    pl_buf[0][0] = 8'hA1; pl_buf[0][1] = 8'hA2; pl_buf[0][2] = 8'hA3;
    model_pkt(0, 12'd6, 3);
    t_valid[0] = 1'b1; t_tid[0] = 12'd6; t_data[0] = 8'hA1; t_last[0] = 1'b0;
    @(posedge aclk); @(posedge aclk); #1;
    t_data[0] = 8'hA2;
    #1;
    aresetn = 1'b0;
    model_reset();
    #1;
    check_zero("rst_pay");
    t_valid[0] = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    pl_buf[0][0] = 8'hB1;
    send_pkt(0, 12'd6, 1, 0, 1'b0, st, sc);
    chk("rst_pay_stall", st, 1);
    drain("rst_pay");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
